// File: rtl/tetris_pkg.sv
// Shared command codes and arbiter state for the tetris input front end and game core.
package tetris_pkg;

   localparam logic [2:0] CTRL_NONE   = 3'd0;
   localparam logic [2:0] CTRL_HOLD   = 3'd1;
   localparam logic [2:0] CTRL_ROTATE = 3'd2;
   localparam logic [2:0] CTRL_LEFT   = 3'd3;
   localparam logic [2:0] CTRL_RIGHT  = 3'd4;
   localparam logic [2:0] CTRL_DOWN   = 3'd5;
   localparam logic [2:0] CTRL_BAR    = 3'd6;

   // Pending-source indices, lowest index wins arbitration.
   localparam int SRC_HOLD   = 0;
   localparam int SRC_ROTATE = 1;
   localparam int SRC_LEFT   = 2;
   localparam int SRC_RIGHT  = 3;
   localparam int SRC_BAR    = 4;
   localparam int SRC_DOWN   = 5;
   localparam int NUM_SRC    = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GAP
   } arb_state_e;

   function automatic logic [2:0] first_src(input logic [NUM_SRC-1:0] p);
      first_src = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (p[i]) first_src = 3'(i);
   endfunction

   function automatic logic [2:0] src_code(input logic [2:0] idx);
      case (idx)
         3'd0:    src_code = CTRL_HOLD;
         3'd1:    src_code = CTRL_ROTATE;
         3'd2:    src_code = CTRL_LEFT;
         3'd3:    src_code = CTRL_RIGHT;
         3'd4:    src_code = CTRL_BAR;
         3'd5:    src_code = CTRL_DOWN;
         default: src_code = CTRL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Button/config inputs and command outputs between the board and the input front end.
interface tetris_input_ctrl_if;
   logic [4:0] btn;
   logic       enable;
   logic [1:0] speed;
   logic [2:0] ctrl;
   logic       busy;

   modport master (output btn, enable, speed, input ctrl, busy);
   modport slave  (input btn, enable, speed, output ctrl, busy);
endinterface

// File: rtl/tetris_input_ctrl_btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter, registered rising-edge pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic level,
   output logic rise
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;

   // cnt_q counts consecutive samples that disagree with the accepted level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) level_d = sync2_q;
         else                   cnt_d   = cnt_q + CW'(1);
      end
      rise_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input front end: debounced buttons, gravity and auto-repeat timers,
// serialised into spaced single-cycle command codes for the game core.
module tetris_input_ctrl
   import tetris_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int GRAVITY_PERIOD  = 100000000,
   parameter int REPEAT_DELAY    = 20000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int CMD_GAP         = 64
) (
   input logic           clk,
   input logic           reset_n,
   tetris_input_ctrl_if.slave io
);
   localparam int GW   = (GRAVITY_PERIOD > 1) ? $clog2(GRAVITY_PERIOD) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam int GAPW = $clog2(CMD_GAP + 1);
   localparam logic [RW-1:0]   REP_DLY  = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0]   REP_PER  = RW'(REPEAT_PERIOD);
   localparam logic [GAPW-1:0] GAP_LAST = GAPW'(CMD_GAP);

   logic [4:0] lvl, rise;
   logic       unused_lvl;

   for (genvar i = 0; i < 5; i++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk     (clk),
         .reset_n (reset_n),
         .btn_raw (io.btn[i]),
         .level   (lvl[i]),
         .rise    (rise[i])
      );
   end
   assign unused_lvl = ^{lvl[4], lvl[1:0]};

   logic [GW-1:0]          grav_q, grav_d, grav_lim;
   logic                   grav_wrap;
   logic [1:0][RW-1:0]     rep_q, rep_d;
   logic [1:0]             rep_ph_q, rep_ph_d, rep_fire;
   logic [NUM_SRC-1:0]     pend_q, pend_d, pend_set, pend_clr;
   arb_state_e             state_q;
   logic [2:0]             sel_q;
   logic [GAPW-1:0]        gap_q;
   logic [2:0]             ctrl_q;
   logic                   busy_q;

   // Using >= lets a speed-up take effect immediately when the count is already past the new limit.
   always_comb begin
      grav_lim  = GW'((GRAVITY_PERIOD >> {io.speed, 1'b0}) - 1);
      grav_d    = grav_q;
      grav_wrap = 1'b0;
      if (io.enable) begin
         if (grav_q >= grav_lim) begin
            grav_d    = '0;
            grav_wrap = 1'b1;
         end else begin
            grav_d = grav_q + GW'(1);
         end
      end
   end

   // rep_ph_q: 0 = waiting out the initial delay, 1 = periodic repeat.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         rep_d[d]    = rep_q[d];
         rep_ph_d[d] = rep_ph_q[d];
         rep_fire[d] = 1'b0;
         if (!lvl[SRC_LEFT + d]) begin
            rep_d[d]    = '0;
            rep_ph_d[d] = 1'b0;
         end else if (io.enable) begin
            if (rep_q[d] == (rep_ph_q[d] ? REP_PER : REP_DLY)) begin
               rep_fire[d] = 1'b1;
               rep_d[d]    = RW'(1);
               rep_ph_d[d] = 1'b1;
            end else begin
               rep_d[d] = rep_q[d] + RW'(1);
            end
         end
      end
   end

   always_comb begin
      pend_set = {grav_wrap, rise[4], rise[3] | rep_fire[1], rise[2] | rep_fire[0],
                  rise[1], rise[0]};
      pend_clr = (state_q == ST_ISSUE) ? (NUM_SRC'(1) << sel_q) : '0;
      pend_d   = (pend_q & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grav_q   <= '0;
         rep_q    <= '0;
         rep_ph_q <= '0;
         pend_q   <= '0;
      end else begin
         grav_q   <= grav_d;
         rep_q    <= rep_d;
         rep_ph_q <= rep_ph_d;
         pend_q   <= pend_d;
      end
   end

   // GAP holds for CMD_GAP+1 state cycles so busy stays high for CMD_GAP cycles after the code.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         gap_q   <= '0;
         ctrl_q  <= CTRL_NONE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (|pend_q) begin
               sel_q   <= first_src(pend_q);
               state_q <= ST_ISSUE;
            end
            ST_ISSUE: begin
               ctrl_q  <= src_code(sel_q);
               busy_q  <= 1'b1;
               gap_q   <= '0;
               state_q <= ST_GAP;
            end
            ST_GAP: begin
               ctrl_q <= CTRL_NONE;
               if (gap_q == GAP_LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q + GAPW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign io.ctrl = ctrl_q;
   assign io.busy = busy_q;
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Randomised bench for tetris_input_ctrl against a timestamp-based reference model.
module tb_tetris_input_ctrl;
   import tetris_pkg::*;

   localparam int DB = 4;
   localparam int GP = 1000;
   localparam int RD = 50;
   localparam int RP = 20;
   localparam int CG = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   tetris_input_ctrl_if io ();

   tetris_input_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .GRAVITY_PERIOD  (GP),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CMD_GAP         (CG)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io      (io)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: history windows for debounce, elapsed-time counts for the
   // timers, and absolute cycle stamps for when the arbiter issues and frees up.
   int          code_of [6] = '{1, 2, 3, 4, 6, 5};
   bit [4:0]    m_s1, m_s2, m_lv, m_rs;
   bit [DB-1:0] m_hist [5];
   bit [5:0]    m_pend;
   int          m_gcnt;
   int          m_held [2];
   int          cyc, issue_at, busy_end, next_ok, pick;
   int          m_ctrl;
   bit          m_busy;

   int          seen [8];
   int          codes [$];
   logic [2:0]  prev_ctrl;
   logic [4:0]  bmask;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lv = '0; m_rs = '0;
      for (int i = 0; i < 5; i++) m_hist[i] = '0;
      m_pend = '0; m_gcnt = 0; m_held[0] = 0; m_held[1] = 0;
      cyc = 0; issue_at = -1; busy_end = -1; next_ok = 0; pick = 0;
      m_ctrl = 0; m_busy = 1'b0;
   endtask

   task automatic model_step(input bit [4:0] b, input bit en, input bit [1:0] sp);
      bit [5:0] set, clr;
      bit [4:0] nlv, nrs;
      int lim;
      set = {1'b0, m_rs};
      clr = '0;
      lim = (GP >> (2 * sp)) - 1;
      if (en) begin
         if (m_gcnt >= lim) begin m_gcnt = 0; set[5] = 1'b1; end
         else m_gcnt++;
      end
      for (int d = 0; d < 2; d++) begin
         if (!m_lv[2 + d]) m_held[d] = 0;
         else if (en) begin
            if (m_held[d] == RD || (m_held[d] > RD && (m_held[d] - RD) % RP == 0))
               set[2 + d] = 1'b1;
            m_held[d]++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
         nlv[i] = (m_hist[i] == {DB{~m_lv[i]}}) ? ~m_lv[i] : m_lv[i];
         nrs[i] = nlv[i] & ~m_lv[i];
      end
      m_lv = nlv; m_rs = nrs;
      m_s2 = m_s1; m_s1 = b;
      m_ctrl = 0;
      if (cyc == issue_at) begin
         m_ctrl = code_of[pick];
         clr[pick] = 1'b1;
      end
      m_busy = (cyc >= issue_at) && (cyc <= busy_end);
      if (cyc >= next_ok && m_pend != 0) begin
         for (int i = 5; i >= 0; i--) if (m_pend[i]) pick = i;
         issue_at = cyc + 1;
         busy_end = cyc + 1 + CG;
         next_ok  = cyc + CG + 3;
      end
      m_pend = (m_pend & ~clr) | set;
      cyc++;
   endtask

   task automatic tick();
      model_step(io.btn, io.enable, io.speed);
      @(negedge clk);
      chk("ctrl", io.ctrl, m_ctrl);
      chk("busy", io.busy, m_busy);
      chk("ctrl_b2b", (prev_ctrl != 0 && io.ctrl != 0), 0);
      prev_ctrl = io.ctrl;
      if (io.ctrl != 0) begin
         seen[io.ctrl]++;
         codes.push_back(int'(io.ctrl));
      end
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 8; i++) seen[i] = 0;
      codes.delete();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   initial begin
      io.btn = 5'b11111; io.enable = 1'b1; io.speed = 2'd0;
      prev_ctrl = '0;
      model_reset();
      clear_seen();
      repeat (6) begin
         @(negedge clk);
         chk("rst_ctrl", io.ctrl, 0);
         chk("rst_busy", io.busy, 0);
      end
      reset_n = 1'b1;

      // Buttons already held at reset release; nothing may issue before debounce.
      run(6);
      chk("post_rst_quiet", seen[1] + seen[2] + seen[3] + seen[4] + seen[6], 0);
      run(80);
      io.btn = '0; run(60);

      // Single rotate press, counters frozen to keep the sequence deterministic.
      io.enable = 1'b0; run(20); clear_seen();
      io.btn = 5'b00010; run(10);
      io.btn = '0; run(40);
      chk("rotate_once", seen[CTRL_ROTATE], 1);

      // Bounce on left every two cycles.
      clear_seen();
      for (int i = 0; i < 10; i++) begin
         io.btn = (i % 2 == 0) ? 5'b00100 : 5'b00000;
         run(2);
      end
      io.btn = '0; run(30);
      chk("bounce_no_left", seen[CTRL_LEFT], 0);

      // Simultaneous hold+left+bar.
      clear_seen();
      io.btn = 5'b10101; run(10);
      io.btn = '0; run(60);
      chk("seq_len", codes.size(), 3);
      if (codes.size() == 3) begin
         chk("seq0", codes[0], CTRL_HOLD);
         chk("seq1", codes[1], CTRL_LEFT);
         chk("seq2", codes[2], CTRL_BAR);
      end

      // Gravity at two speeds, then frozen.
      io.enable = 1'b1; clear_seen(); run(2200);
      chk("grav_s0", seen[CTRL_DOWN] >= 2, 1);
      io.speed = 2'd1; clear_seen(); run(700);
      chk("grav_s1", seen[CTRL_DOWN] >= 2, 1);
      io.speed = 2'd0; io.enable = 1'b0; run(20); clear_seen(); run(2000);
      chk("grav_frozen", seen[CTRL_DOWN], 0);

      // Hold right 200 cycles: first press plus repeats at +50, +70 .. +190.
      io.enable = 1'b1; clear_seen();
      io.btn = 5'b01000; run(200);
      io.btn = '0; run(100);
      chk("right_cnt", seen[CTRL_RIGHT], 9);

      // Randomised segments.
      for (int s = 0; s < 150; s++) begin
         io.enable = ($urandom_range(0, 7) != 0);
         io.speed  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: begin io.btn = 5'($urandom); run($urandom_range(1, 120)); end
            1: begin
               bmask = 5'($urandom);
               repeat ($urandom_range(2, 12)) begin
                  io.btn = io.btn ^ bmask;
                  run($urandom_range(1, 4));
               end
            end
            2: begin io.btn = '0; run($urandom_range(1, 60)); end
            default: begin
               io.btn = 5'(1 << $urandom_range(0, 4));
               run($urandom_range(5, 150));
            end
         endcase
      end
      io.btn = '0; run(50);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
